// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - receive-side checker for a free-running mod-2**WIDTH up-counter stream
// Optional: define COUNT_MONITOR_HOLD_EN to accept a repeated sample as a legal hold.
module count_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VALID,
  input  logic [WIDTH-1:0] Q,
  output logic             LOCKED,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic [WIDTH-1:0] EXPECTED
);

  localparam int RUN_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [RUN_W:0]   LOCK_TGT = (RUN_W + 1)'(LOCK_CNT);

  typedef enum logic {
    ST_ACQ,
    ST_LOCK
  } state_t;

  state_t           state;
  logic             has_prev;
  logic [RUN_W-1:0] run;

  logic           match;
  logic           hold_hit;
  logic [RUN_W:0] run_next;

  always_comb begin
    match    = has_prev && (Q == EXPECTED);
    run_next = {1'b0, run} + (RUN_W + 1)'(1);
`ifdef COUNT_MONITOR_HOLD_EN
    // A repeat of the last sample means the source is stalled, not broken.
    hold_hit = has_prev && (Q == (EXPECTED - ONE));
`else
    hold_hit = 1'b0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_ACQ;
      has_prev  <= 1'b0;
      run       <= '0;
      LOCKED    <= 1'b0;
      ERR       <= 1'b0;
      ERR_COUNT <= '0;
      EXPECTED  <= '0;
    end else begin
      ERR <= 1'b0;
      if (VALID && !hold_hit) begin
        EXPECTED <= Q + ONE;
        has_prev <= 1'b1;
        case (state)
          ST_ACQ: begin
            if (!has_prev) begin
              run <= '0;
            end else if (match) begin
              if (run_next == LOCK_TGT) begin
                state  <= ST_LOCK;
                LOCKED <= 1'b1;
                run    <= '0;
              end else begin
                run <= run_next[RUN_W-1:0];
              end
            end else begin
              run <= '0;
            end
          end
          ST_LOCK: begin
            if (!match) begin
              // The breaking sample seeds EXPECTED so re-acquisition starts from it.
              ERR    <= 1'b1;
              state  <= ST_ACQ;
              LOCKED <= 1'b0;
              run    <= '0;
              if (!(&ERR_COUNT)) begin
                ERR_COUNT <= ERR_COUNT + ERR_W'(1);
              end
            end
          end
          default: begin
            state  <= ST_ACQ;
            LOCKED <= 1'b0;
            run    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - scoreboard bench for count_monitor (default and saturating builds)
module tb_count_monitor;

`ifdef COUNT_MONITOR_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, valid_a = 1'b0;
  logic [3:0] q_a = '0;
  logic       lock_a, err_a;
  logic [7:0] cnt_a;
  logic [3:0] exp_a;

  logic       rst_b = 1'b1, valid_b = 1'b0;
  logic [3:0] q_b = '0;
  logic       lock_b, err_b;
  logic [1:0] cnt_b;
  logic [3:0] exp_b;

  count_monitor #(.WIDTH(4), .LOCK_CNT(4), .ERR_W(8)) dut_a (
    .CLK(clk), .RST(rst_a), .VALID(valid_a), .Q(q_a),
    .LOCKED(lock_a), .ERR(err_a), .ERR_COUNT(cnt_a), .EXPECTED(exp_a)
  );

  count_monitor #(.WIDTH(4), .LOCK_CNT(1), .ERR_W(2)) dut_b (
    .CLK(clk), .RST(rst_b), .VALID(valid_b), .Q(q_b),
    .LOCKED(lock_b), .ERR(err_b), .ERR_COUNT(cnt_b), .EXPECTED(exp_b)
  );

  typedef struct {
    string      tag;
    logic       locked;
    logic       err;
    logic [7:0] cnt;
    logic [3:0] exp;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic step_a(input string tag, input logic r, input logic v, input logic [3:0] q,
                        input logic el, input logic ee, input logic [7:0] ec, input logic [3:0] ex);
    exp_t e;
    @(negedge clk);
    rst_a = r; valid_a = v; q_a = q;
    @(posedge clk);
    #1;
    e.tag = tag; e.locked = el; e.err = ee; e.cnt = ec; e.exp = ex;
    qa.push_back(e);
  endtask

  task automatic step_b(input string tag, input logic r, input logic v, input logic [3:0] q,
                        input logic el, input logic ee, input logic [7:0] ec, input logic [3:0] ex);
    exp_t e;
    @(negedge clk);
    rst_b = r; valid_b = v; q_b = q;
    @(posedge clk);
    #1;
    e.tag = tag; e.locked = el; e.err = ee; e.cnt = ec; e.exp = ex;
    qb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (qa.size() != 0) begin
      ea = qa.pop_front();
      n_tests++;
      if (lock_a !== ea.locked || err_a !== ea.err || cnt_a !== ea.cnt || exp_a !== ea.exp) begin
        n_fail++;
        $display("FAIL %s: got L=%0b E=%0b C=%0d X=%0d, want L=%0b E=%0b C=%0d X=%0d",
                 ea.tag, lock_a, err_a, cnt_a, exp_a, ea.locked, ea.err, ea.cnt, ea.exp);
      end
    end
    if (qb.size() != 0) begin
      eb = qb.pop_front();
      n_tests++;
      if (lock_b !== eb.locked || err_b !== eb.err || {6'b0, cnt_b} !== eb.cnt || exp_b !== eb.exp) begin
        n_fail++;
        $display("FAIL %s: got L=%0b E=%0b C=%0d X=%0d, want L=%0b E=%0b C=%0d X=%0d",
                 eb.tag, lock_b, err_b, cnt_b, exp_b, eb.locked, eb.err, eb.cnt, eb.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    // Acquire from reset: lock after the fifth sample (four correct steps).
    step_a("a_reset", 1, 0, 4'd0, 0, 0, 8'd0, 4'd0);
    for (int q = 0; q < 4; q++) step_a("acq", 0, 1, 4'(q), 0, 0, 8'd0, 4'(q + 1));
    step_a("acq_lock", 0, 1, 4'd4, 1, 0, 8'd0, 4'd5);

    // Run through the 15 -> 0 wrap while locked.
    for (int q = 5; q < 18; q++) step_a("wrap", 0, 1, 4'(q), 1, 0, 8'd0, 4'(q + 1));

    // Break and relock.
    for (int q = 2; q < 7; q++) step_a("pre_break", 0, 1, 4'(q), 1, 0, 8'd0, 4'(q + 1));
    step_a("break", 0, 1, 4'd9, 0, 1, 8'd1, 4'd10);
    step_a("reacq10", 0, 1, 4'd10, 0, 0, 8'd1, 4'd11);
    step_a("reacq11", 0, 1, 4'd11, 0, 0, 8'd1, 4'd12);
    step_a("reacq12", 0, 1, 4'd12, 0, 0, 8'd1, 4'd13);
    step_a("relock13", 0, 1, 4'd13, 1, 0, 8'd1, 4'd14);

    // VALID gaps with garbage on Q are ignored.
    for (int q = 14; q < 20; q++) step_a("pre_gap", 0, 1, 4'(q), 1, 0, 8'd1, 4'(q + 1));
    step_a("gap0", 0, 0, 4'd9, 1, 0, 8'd1, 4'd4);
    step_a("gap1", 0, 0, 4'd0, 1, 0, 8'd1, 4'd4);
    step_a("gap2", 0, 0, 4'd7, 1, 0, 8'd1, 4'd4);
    step_a("post_gap", 0, 1, 4'd4, 1, 0, 8'd1, 4'd5);

    // Repeated sample: hold when enabled, otherwise a break.
    step_a("h5", 0, 1, 4'd5, 1, 0, 8'd1, 4'd6);
    step_a("h6", 0, 1, 4'd6, 1, 0, 8'd1, 4'd7);
    step_a("h7", 0, 1, 4'd7, 1, 0, 8'd1, 4'd8);
    step_a("h7_repeat", 0, 1, 4'd7, HOLD, !HOLD, HOLD ? 8'd1 : 8'd2, 4'd8);
    step_a("h8", 0, 1, 4'd8, HOLD, 0, HOLD ? 8'd1 : 8'd2, 4'd9);
    step_a("h9", 0, 1, 4'd9, HOLD, 0, HOLD ? 8'd1 : 8'd2, 4'd10);
    step_a("h10", 0, 1, 4'd10, HOLD, 0, HOLD ? 8'd1 : 8'd2, 4'd11);
    step_a("h11", 0, 1, 4'd11, 1, 0, HOLD ? 8'd1 : 8'd2, 4'd12);
    step_a("h12", 0, 1, 4'd12, 1, 0, HOLD ? 8'd1 : 8'd2, 4'd13);

    // Reset while locked, with VALID high: reset wins.
    step_a("rst_locked", 1, 1, 4'd13, 0, 0, 8'd0, 4'd0);
    step_a("first_after_rst", 0, 1, 4'd3, 0, 0, 8'd0, 4'd4);
    step_a("idle_after_rst", 0, 0, 4'd15, 0, 0, 8'd0, 4'd4);
    step_a("second_after_rst", 0, 1, 4'd4, 0, 0, 8'd0, 4'd5);

    // Saturating counter: LOCK_CNT=1, ERR_W=2, five break/relock cycles.
    step_b("b_reset", 1, 0, 4'd0, 0, 0, 8'd0, 4'd0);
    step_b("b_first", 0, 1, 4'd0, 0, 0, 8'd0, 4'd1);
    step_b("b_lock", 0, 1, 4'd1, 1, 0, 8'd0, 4'd2);
    step_b("b_brk1", 0, 1, 4'd5, 0, 1, 8'd1, 4'd6);
    step_b("b_rl1", 0, 1, 4'd6, 1, 0, 8'd1, 4'd7);
    step_b("b_brk2", 0, 1, 4'd0, 0, 1, 8'd2, 4'd1);
    step_b("b_rl2", 0, 1, 4'd1, 1, 0, 8'd2, 4'd2);
    step_b("b_brk3", 0, 1, 4'd9, 0, 1, 8'd3, 4'd10);
    step_b("b_rl3", 0, 1, 4'd10, 1, 0, 8'd3, 4'd11);
    step_b("b_brk4", 0, 1, 4'd3, 0, 1, 8'd3, 4'd4);
    step_b("b_rl4", 0, 1, 4'd4, 1, 0, 8'd3, 4'd5);
    step_b("b_brk5", 0, 1, 4'd8, 0, 1, 8'd3, 4'd9);
    step_b("b_rl5", 0, 1, 4'd9, 1, 0, 8'd3, 4'd10);

    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
